// File: rtl/pop_mon_pkg.sv
// Shared definitions for the POP sequence monitor: FSM state encoding,
// error codes and the tolerance helper used by the width check.
package pop_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUMP   = 3'd1,
    ST_GAPA   = 3'd2,
    ST_MW     = 3'd3,
    ST_GAPB   = 3'd4,
    ST_PROBE  = 3'd5,
    ST_REPORT = 3'd6
  } pop_state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_ORDER   = 3'd2;
  localparam logic [2:0] ERR_OVERLAP = 3'd3;
  localparam logic [2:0] ERR_SAMPLE  = 3'd4;
  localparam logic [2:0] ERR_WIDTH   = 3'd5;

  // True when |meas - exp| <= tol (inclusive bound).
  function automatic logic within_tol(input logic [31:0] meas_i,
                                      input logic [31:0] exp_i,
                                      input logic [31:0] tol_i);
    logic [31:0] diff;
    diff = (meas_i >= exp_i) ? (meas_i - exp_i) : (exp_i - meas_i);
    return (diff <= tol_i);
  endfunction

endpackage

// File: rtl/pop_edge_detect.sv
// Level/edge extraction for one monitored pulse line.
// With POP_MON_SYNC_EN defined the input first passes a 2-flop
// synchroniser (adds 2 clk of latency); otherwise it is used directly.
module pop_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic lvl_s;
  logic prev_q;

`ifdef POP_MON_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchroniser for externally looped-back pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign lvl_s = sync_q[1];
`else
  assign lvl_s = d_i;
`endif

  // History register: previous sampled level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= lvl_s;
    end
  end

  assign lvl_o  = lvl_s;
  assign rise_o = lvl_s & ~prev_q;
  assign fall_o = ~lvl_s & prev_q;

endmodule

// File: rtl/pop_sequence_monitor.sv
// Receiving-end monitor of the POP pulse interface. Measures one full
// pump -> gap -> MW -> gap -> probe cycle, checks order, overlap, sample
// gating, timeout and widths, and reports each cycle with a 1-clk strobe.
// Optional build macro: POP_MON_SYNC_EN (2-flop input synchronisers).
module pop_sequence_monitor
  import pop_mon_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned PUMP_EXP      = 1000,
  parameter int unsigned GAPA_EXP      = 50,
  parameter int unsigned MW_EXP        = 200,
  parameter int unsigned GAPB_EXP      = 50,
  parameter int unsigned PROBE_EXP     = 100,
  parameter int unsigned TOL           = 2,
  parameter int unsigned TIMEOUT_TICKS = 60000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pump,
  input  logic             MW,
  input  logic             probe,
  input  logic             sample,
  output logic             cycle_valid,
  output logic             cycle_ok,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] pump_width,
  output logic [CNT_W-1:0] gap_a,
  output logic [CNT_W-1:0] mw_width,
  output logic [CNT_W-1:0] gap_b,
  output logic [CNT_W-1:0] probe_width
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_TICKS);

  // Edge-detected views of the four monitored lines.
  logic p_lvl_s, p_rise_s, p_fall_s;
  logic m_lvl_s, m_rise_s, m_fall_s;
  logic pr_lvl_s, pr_rise_s, pr_fall_s;
  logic smp_lvl_s, unused_smp_rise_s, unused_smp_fall_s;

  pop_edge_detect u_ed_pump (
    .clk(clk), .rst_n(reset), .d_i(pump),
    .lvl_o(p_lvl_s), .rise_o(p_rise_s), .fall_o(p_fall_s)
  );
  pop_edge_detect u_ed_mw (
    .clk(clk), .rst_n(reset), .d_i(MW),
    .lvl_o(m_lvl_s), .rise_o(m_rise_s), .fall_o(m_fall_s)
  );
  pop_edge_detect u_ed_probe (
    .clk(clk), .rst_n(reset), .d_i(probe),
    .lvl_o(pr_lvl_s), .rise_o(pr_rise_s), .fall_o(pr_fall_s)
  );
  pop_edge_detect u_ed_sample (
    .clk(clk), .rst_n(reset), .d_i(sample),
    .lvl_o(smp_lvl_s), .rise_o(unused_smp_rise_s), .fall_o(unused_smp_fall_s)
  );

  pop_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [CNT_W-1:0] pw_q, pw_d, ga_q, ga_d, mwm_q, mwm_d, gb_q, gb_d, prm_q, prm_d;
  logic [2:0]       fault_s, rep_err_s;
  logic             timeout_s, order_s, overlap_s, sample_s, widths_ok_s;

  logic             cycle_valid_q, cycle_ok_q;
  logic [2:0]       err_code_q;
  logic [CNT_W-1:0] pump_width_q, gap_a_q, mw_width_q, gap_b_q, probe_width_q;

  // Error detection, phase counting and next-state selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pw_d      = pw_q;
    ga_d      = ga_q;
    mwm_d     = mwm_q;
    gb_d      = gb_q;
    prm_d     = prm_q;
    rep_err_s = ERR_NONE;
    fault_s   = ERR_NONE;

    timeout_s = (cnt_q >= TIMEOUT_C);
    order_s   = p_rise_s | (pr_rise_s & ((state_q == ST_PUMP) | (state_q == ST_GAPA)));
    overlap_s = (p_lvl_s & m_lvl_s) | (p_lvl_s & pr_lvl_s) | (m_lvl_s & pr_lvl_s);
    // The probe-fall cycle itself is not gated: probe is already low there.
    sample_s  = ~smp_lvl_s & (pr_rise_s | ((state_q == ST_PROBE) & pr_lvl_s));

    if (timeout_s) begin
      fault_s = ERR_TIMEOUT;
    end else if (order_s) begin
      fault_s = ERR_ORDER;
    end else if (overlap_s) begin
      fault_s = ERR_OVERLAP;
    end else if (sample_s) begin
      fault_s = ERR_SAMPLE;
    end else begin
      fault_s = ERR_NONE;
    end

    cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    // Probe width is still in the counter on the probe-fall cycle.
    widths_ok_s = within_tol(32'(pw_q),  PUMP_EXP,  TOL) &
                  within_tol(32'(ga_q),  GAPA_EXP,  TOL) &
                  within_tol(32'(mwm_q), MW_EXP,    TOL) &
                  within_tol(32'(gb_q),  GAPB_EXP,  TOL) &
                  within_tol(32'(cnt_q), PROBE_EXP, TOL);

    case (state_q)
      ST_IDLE, ST_REPORT: begin
        if (p_rise_s) begin
          state_d = ST_PUMP;
          cnt_d   = CNT_ONE;
          pw_d    = '0;
          ga_d    = '0;
          mwm_d   = '0;
          gb_d    = '0;
          prm_d   = '0;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_PUMP: begin
        if (fault_s != ERR_NONE) begin
          state_d   = ST_REPORT;
          rep_err_s = fault_s;
          cnt_d     = '0;
          pw_d      = cnt_q;
        end else if (p_fall_s) begin
          state_d = m_rise_s ? ST_MW : ST_GAPA;
          cnt_d   = CNT_ONE;
          pw_d    = cnt_q;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_GAPA: begin
        if (fault_s != ERR_NONE) begin
          state_d   = ST_REPORT;
          rep_err_s = fault_s;
          cnt_d     = '0;
          ga_d      = cnt_q;
        end else if (m_rise_s) begin
          state_d = ST_MW;
          cnt_d   = CNT_ONE;
          ga_d    = cnt_q;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_MW: begin
        if (fault_s != ERR_NONE) begin
          state_d   = ST_REPORT;
          rep_err_s = fault_s;
          cnt_d     = '0;
          mwm_d     = cnt_q;
        end else if (m_fall_s) begin
          state_d = pr_rise_s ? ST_PROBE : ST_GAPB;
          cnt_d   = CNT_ONE;
          mwm_d   = cnt_q;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_GAPB: begin
        if (fault_s != ERR_NONE) begin
          state_d   = ST_REPORT;
          rep_err_s = fault_s;
          cnt_d     = '0;
          gb_d      = cnt_q;
        end else if (pr_rise_s) begin
          state_d = ST_PROBE;
          cnt_d   = CNT_ONE;
          gb_d    = cnt_q;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_PROBE: begin
        if (fault_s != ERR_NONE) begin
          state_d   = ST_REPORT;
          rep_err_s = fault_s;
          cnt_d     = '0;
          prm_d     = cnt_q;
        end else if (pr_fall_s) begin
          state_d   = ST_REPORT;
          rep_err_s = widths_ok_s ? ERR_NONE : ERR_WIDTH;
          cnt_d     = '0;
          prm_d     = cnt_q;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, phase counter and per-phase measurement registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pw_q    <= '0;
      ga_q    <= '0;
      mwm_q   <= '0;
      gb_q    <= '0;
      prm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      ga_q    <= ga_d;
      mwm_q   <= mwm_d;
      gb_q    <= gb_d;
      prm_q   <= prm_d;
    end
  end

  // Result latch: loads on entry to REPORT, holds until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_valid_q <= 1'b0;
      cycle_ok_q    <= 1'b0;
      err_code_q    <= ERR_NONE;
      pump_width_q  <= '0;
      gap_a_q       <= '0;
      mw_width_q    <= '0;
      gap_b_q       <= '0;
      probe_width_q <= '0;
    end else if (state_d == ST_REPORT) begin
      cycle_valid_q <= 1'b1;
      cycle_ok_q    <= (rep_err_s == ERR_NONE);
      err_code_q    <= rep_err_s;
      pump_width_q  <= pw_d;
      gap_a_q       <= ga_d;
      mw_width_q    <= mwm_d;
      gap_b_q       <= gb_d;
      probe_width_q <= prm_d;
    end else begin
      cycle_valid_q <= 1'b0;
    end
  end

  assign cycle_valid = cycle_valid_q;
  assign cycle_ok    = cycle_ok_q;
  assign err_code    = err_code_q;
  assign pump_width  = pump_width_q;
  assign gap_a       = gap_a_q;
  assign mw_width    = mw_width_q;
  assign gap_b       = gap_b_q;
  assign probe_width = probe_width_q;

endmodule

// File: tb/tb_pop_sequence_monitor.sv
// Self-checking bench for pop_sequence_monitor: table of directed POP
// cycles plus hand-written order/overlap/timeout/reset sequences.
`timescale 1ns/1ps
module tb_pop_sequence_monitor;

  localparam int TMO = 60000;
`ifdef POP_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pump = 1'b0, mw = 1'b0, probe = 1'b0, sample = 1'b0;

  logic        cycle_valid, cycle_ok;
  logic [2:0]  err_code;
  logic [15:0] pump_width, gap_a, mw_width, gap_b, probe_width;

  logic        z_valid, z_ok;
  logic [2:0]  z_err;
  logic [15:0] z_pw, z_ga, z_mw, z_gb, z_pr;

  pop_sequence_monitor u_dut (
    .clk(clk), .reset(reset), .pump(pump), .MW(mw), .probe(probe), .sample(sample),
    .cycle_valid(cycle_valid), .cycle_ok(cycle_ok), .err_code(err_code),
    .pump_width(pump_width), .gap_a(gap_a), .mw_width(mw_width),
    .gap_b(gap_b), .probe_width(probe_width)
  );

  // Second instance expecting zero-length gaps.
  pop_sequence_monitor #(.GAPA_EXP(0), .GAPB_EXP(0)) u_dut_zg (
    .clk(clk), .reset(reset), .pump(pump), .MW(mw), .probe(probe), .sample(sample),
    .cycle_valid(z_valid), .cycle_ok(z_ok), .err_code(z_err),
    .pump_width(z_pw), .gap_a(z_ga), .mw_width(z_mw),
    .gap_b(z_gb), .probe_width(z_pr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts every sampled cycle_valid high and its cycle.
  int vcount = 0;
  int vcyc = 0;
  always @(negedge clk) begin
    if (cycle_valid === 1'b1) begin
      vcount <= vcount + 1;
      vcyc   <= cyc;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic p, input logic m, input logic pr, input logic s, input int n);
    for (int i = 0; i < n; i++) begin
      pump = p; mw = m; probe = pr; sample = s;
      @(negedge clk);
    end
  endtask

  typedef struct {
    string name;
    int p, ga, m, gb, r, drop;
    int e_err, e_pw, e_ga, e_mw, e_gb, e_pr;
    int e_alt;
  } vec_t;

  // Drive one POP cycle; sample is high from one cycle before probe to one after.
  task automatic drive_vec(input vec_t v);
    int s0, total;
    s0 = v.p + v.ga + v.m + v.gb;
    total = s0 + v.r + 6;
    for (int t = 0; t < total; t++) begin
      pump   = (t < v.p);
      mw     = (t >= v.p + v.ga) && (t < v.p + v.ga + v.m);
      probe  = (t >= s0) && (t < s0 + v.r);
      sample = (t >= s0 - 1) && (t <= s0 + v.r) && !((v.drop >= 0) && (t == s0 + v.drop));
      @(negedge clk);
    end
    pump = 1'b0; mw = 1'b0; probe = 1'b0; sample = 1'b0;
  endtask

  // Wait (bounded) for a report, then compare the latched result.
  task automatic expect_rep(input string name, input int base, input int e_err,
                            input int e_pw, input int e_ga, input int e_mw,
                            input int e_gb, input int e_pr);
    for (int i = 0; i < 20 && vcount == base; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({name, "_strobes"}, vcount - base, 1);
    check({name, "_ok"},    int'(cycle_ok), (e_err == 0) ? 1 : 0);
    check({name, "_err"},   int'(err_code), e_err);
    check({name, "_pw"},    int'(pump_width), e_pw);
    check({name, "_ga"},    int'(gap_a), e_ga);
    check({name, "_mw"},    int'(mw_width), e_mw);
    check({name, "_gb"},    int'(gap_b), e_gb);
    check({name, "_pr"},    int'(probe_width), e_pr);
  endtask

  vec_t vecs[9];

  initial begin
    int base, c0, s0;

    vecs[0] = '{"nominal",   1000, 50, 200, 50, 100, -1, 0, 1000, 50, 200, 50, 100, 5};
    vecs[1] = '{"mw202",     1000, 50, 202, 50, 100, -1, 0, 1000, 50, 202, 50, 100, -1};
    vecs[2] = '{"mw203",     1000, 50, 203, 50, 100, -1, 5, 1000, 50, 203, 50, 100, -1};
    vecs[3] = '{"mw198",     1000, 50, 198, 50, 100, -1, 0, 1000, 50, 198, 50, 100, -1};
    vecs[4] = '{"probe97",   1000, 50, 200, 50,  97, -1, 5, 1000, 50, 200, 50,  97, -1};
    vecs[5] = '{"pump998",    998, 50, 200, 50, 100, -1, 0,  998, 50, 200, 50, 100, -1};
    vecs[6] = '{"zerogap",   1000,  0, 200,  0, 100, -1, 5, 1000,  0, 200,  0, 100, 0};
    vecs[7] = '{"smp_mid",   1000, 50, 200, 50, 100, 40, 4, 1000, 50, 200, 50,  40, -1};
    vecs[8] = '{"smp_rise",  1000, 50, 200, 50, 100,  0, 4, 1000, 50, 200, 50,   0, -1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_valid", int'(cycle_valid), 0);
    check("rst_ok",    int'(cycle_ok), 0);
    check("rst_err",   int'(err_code), 0);
    check("rst_pw",    int'(pump_width), 0);
    check("rst_ga",    int'(gap_a), 0);
    check("rst_mw",    int'(mw_width), 0);
    check("rst_gb",    int'(gap_b), 0);
    check("rst_pr",    int'(probe_width), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven cycles.
    for (int k = 0; k < 9; k++) begin
      base = vcount;
      c0 = cyc;
      s0 = vecs[k].p + vecs[k].ga + vecs[k].m + vecs[k].gb;
      drive_vec(vecs[k]);
      expect_rep(vecs[k].name, base, vecs[k].e_err, vecs[k].e_pw, vecs[k].e_ga,
                 vecs[k].e_mw, vecs[k].e_gb, vecs[k].e_pr);
      if (vecs[k].e_err == 0 || vecs[k].e_err == 5) begin
        check({vecs[k].name, "_latency"}, vcyc - c0, s0 + vecs[k].r + 1 + LAT);
      end
      if (vecs[k].e_alt >= 0) begin
        check({vecs[k].name, "_alt_err"}, int'(z_err), vecs[k].e_alt);
        check({vecs[k].name, "_alt_ok"},  int'(z_ok), (vecs[k].e_alt == 0) ? 1 : 0);
      end
    end

    // Order: probe rises during GAPA.
    base = vcount;
    hold(1'b1, 1'b0, 1'b0, 1'b0, 1000);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 20);
    hold(1'b0, 1'b0, 1'b1, 1'b1, 5);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 5);
    expect_rep("order", base, 2, 1000, 20, 0, 0, 0);

    // Overlap: pump still high when MW rises.
    base = vcount;
    hold(1'b1, 1'b0, 1'b0, 1'b0, 1000);
    hold(1'b1, 1'b1, 1'b0, 1'b0, 3);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 5);
    expect_rep("overlap", base, 3, 1000, 0, 0, 0, 0);

    // Timeout: pump rises and nothing else happens.
    base = vcount;
    c0 = cyc;
    hold(1'b1, 1'b0, 1'b0, 1'b0, TMO + 10);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 3);
    expect_rep("timeout", base, 1, TMO, 0, 0, 0, 0);
    check("timeout_latency", vcyc - c0, TMO + 1 + LAT);

    // Reset in the middle of PROBE, then a clean nominal cycle.
    base = vcount;
    hold(1'b1, 1'b0, 1'b0, 1'b0, 1000);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 49);
    hold(1'b0, 1'b0, 1'b0, 1'b1, 1);
    hold(1'b0, 1'b1, 1'b0, 1'b1, 200);
    hold(1'b0, 1'b0, 1'b0, 1'b1, 50);
    hold(1'b0, 1'b0, 1'b1, 1'b1, 50);
    reset = 1'b0;
    hold(1'b0, 1'b0, 1'b0, 1'b0, 3);
    check("midrst_err", int'(err_code), 0);
    check("midrst_pw",  int'(pump_width), 0);
    reset = 1'b1;
    hold(1'b0, 1'b0, 1'b0, 1'b0, 10);
    check("midrst_nostrobe", vcount - base, 0);
    base = vcount;
    drive_vec(vecs[0]);
    expect_rep("after_rst", base, 0, 1000, 50, 200, 50, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
